// File: rtl/adder_pkg.sv
// Shared definitions for the serial adder: FSM state encoding and the
// counter-width helper.
package adder_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Width of a counter that must reach n-1; never narrower than one bit.
  function automatic int cnt_width(input int n);
    int w;
    w = $clog2(n);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/full_adder.sv
// One-bit combinational full adder; the building block of the per-cycle
// ripple chain inside serial_adder.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/serial_adder.sv
// Multi-cycle adder: consumes CHUNK operand bits per clock, LSB first, and
// publishes sum/carry/overflow in a result register held until the next DONE.
module serial_adder
  import adder_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CHUNK = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_carry,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             carry_out,
  output logic             overflow
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int CW     = cnt_width(NCHUNK);

  if (WIDTH < 2 || (WIDTH % CHUNK) != 0) begin : g_param_check
    $error("serial_adder: WIDTH must be >= 2 and a multiple of CHUNK");
  end

  state_t           r_state;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_acc;
  logic [WIDTH-1:0] r_sum;
  logic             r_carry;
  logic             r_a_msb;
  logic             r_b_msb;
  logic             r_cout;
  logic             r_ovf;
  logic             r_busy;
  logic             r_done;

  logic [CHUNK:0]   w_c;
  logic [CHUNK-1:0] w_s;
  logic [WIDTH-1:0] w_acc_next;
  logic             w_last;

  assign w_c[0] = r_carry;

  for (genvar i = 0; i < CHUNK; i++) begin : g_chain
    full_adder u_fa (
      .a    (r_a[i]),
      .b    (r_b[i]),
      .cin  (w_c[i]),
      .s    (w_s[i]),
      .cout (w_c[i+1])
    );
  end

  // Chunk sums enter at the top so that after NCHUNK cycles the LSB chunk
  // has been shifted down to bit 0.
  if (CHUNK == WIDTH) begin : g_acc_full
    assign w_acc_next = w_s;
  end else begin : g_acc_shift
    assign w_acc_next = {w_s, r_acc[WIDTH-1:CHUNK]};
  end

  assign w_last = (r_cnt == CW'(NCHUNK - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_a     <= '0;
      r_b     <= '0;
      r_acc   <= '0;
      r_sum   <= '0;
      r_carry <= 1'b0;
      r_a_msb <= 1'b0;
      r_b_msb <= 1'b0;
      r_cout  <= 1'b0;
      r_ovf   <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            r_a     <= in_a;
            r_b     <= in_b;
            r_carry <= in_carry;
            r_a_msb <= in_a[WIDTH-1];
            r_b_msb <= in_b[WIDTH-1];
            r_acc   <= '0;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
            r_state <= ST_RUN;
          end else begin
            r_state <= ST_IDLE;
          end
        end
        ST_RUN: begin
          r_a     <= r_a >> CHUNK;
          r_b     <= r_b >> CHUNK;
          r_acc   <= w_acc_next;
          r_carry <= w_c[CHUNK];
          r_cnt   <= r_cnt + CW'(1);
          if (w_last) begin
            r_state <= ST_DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_sum   <= w_acc_next;
            r_cout  <= w_c[CHUNK];
            r_ovf   <= (r_a_msb == r_b_msb) && (w_acc_next[WIDTH-1] != r_a_msb);
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign busy      = r_busy;
  assign done      = r_done;
  assign sum       = r_sum;
  assign carry_out = r_cout;
  assign overflow  = r_ovf;

endmodule

// File: tb/tb_serial_adder.sv
// Directed and random checks of serial_adder in three configurations:
// 8/1, 8/4 and 16/2 (WIDTH/CHUNK).
module tb_serial_adder;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // WIDTH=8, CHUNK=1
  logic       start1 = 1'b0, cin1 = 1'b0;
  logic [7:0] a1 = '0, b1 = '0;
  logic       busy1, done1, cout1, ovf1;
  logic [7:0] sum1;

  // WIDTH=8, CHUNK=4
  logic       start2 = 1'b0, cin2 = 1'b0;
  logic [7:0] a2 = '0, b2 = '0;
  logic       busy2, done2, cout2, ovf2;
  logic [7:0] sum2;

  // WIDTH=16, CHUNK=2
  logic        start3 = 1'b0, cin3 = 1'b0;
  logic [15:0] a3 = '0, b3 = '0;
  logic        busy3, done3, cout3, ovf3;
  logic [15:0] sum3;

  serial_adder #(.WIDTH(8), .CHUNK(1)) u_dut1 (
    .clk(clk), .rst(rst), .start(start1), .in_a(a1), .in_b(b1), .in_carry(cin1),
    .busy(busy1), .done(done1), .sum(sum1), .carry_out(cout1), .overflow(ovf1));

  serial_adder #(.WIDTH(8), .CHUNK(4)) u_dut2 (
    .clk(clk), .rst(rst), .start(start2), .in_a(a2), .in_b(b2), .in_carry(cin2),
    .busy(busy2), .done(done2), .sum(sum2), .carry_out(cout2), .overflow(ovf2));

  serial_adder #(.WIDTH(16), .CHUNK(2)) u_dut3 (
    .clk(clk), .rst(rst), .start(start3), .in_a(a3), .in_b(b3), .in_carry(cin3),
    .busy(busy3), .done(done3), .sum(sum3), .carry_out(cout3), .overflow(ovf3));

  int nvec  = 0;
  int nfail = 0;
  int dn3   = 0;

  always @(negedge clk) if (done3) dn3++;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    int bc, dc, dat, w, acc3;
    logic [31:0] etot;
    int          ssum;
    logic        eovf;

    // reset
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk("rst_busy", busy1, 0);
    chk("rst_done", done1, 0);
    chk("rst_sum",  sum1, 0);
    chk("rst_cout", cout1, 0);
    chk("rst_ovf",  ovf1, 0);

    // 0x5A + 0x3C
    a1 = 8'h5A; b1 = 8'h3C; cin1 = 1'b0; start1 = 1'b1;
    bc = 0; dc = 0; dat = 0;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      if (k == 1) start1 = 1'b0;
      if (busy1) bc++;
      if (done1) begin dc++; dat = k; end
    end
    chk("t1_busy_cycles", bc, 8);
    chk("t1_done_count", dc, 1);
    chk("t1_done_cycle", dat, 9);
    chk("t1_sum",  sum1, 8'h96);
    chk("t1_cout", cout1, 0);
    chk("t1_ovf",  ovf1, 1);

    // 0xFF + 0x01, then 0x7F + 0x00 + 1 started in the DONE cycle
    a1 = 8'hFF; b1 = 8'h01; cin1 = 1'b0; start1 = 1'b1;
    for (int k = 1; k <= 9; k++) begin
      @(negedge clk);
      if (k == 1) start1 = 1'b0;
    end
    chk("t2a_done", done1, 1);
    chk("t2a_sum",  sum1, 8'h00);
    chk("t2a_cout", cout1, 1);
    chk("t2a_ovf",  ovf1, 0);
    a1 = 8'h7F; b1 = 8'h00; cin1 = 1'b1; start1 = 1'b1;
    dc = 0; dat = 0;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      if (k == 1) begin
        start1 = 1'b0;
        chk("t2b_busy_b2b", busy1, 1);
        chk("t2b_sum_held", sum1, 8'h00);
        chk("t2b_cout_held", cout1, 1);
      end
      if (done1) begin dc++; dat = k; end
    end
    chk("t2b_done_count", dc, 1);
    chk("t2b_done_cycle", dat, 9);
    chk("t2b_sum",  sum1, 8'h80);
    chk("t2b_cout", cout1, 0);
    chk("t2b_ovf",  ovf1, 1);

    // 0x10 + 0x20 with an ignored start pulse mid-run
    a1 = 8'h10; b1 = 8'h20; cin1 = 1'b0; start1 = 1'b1;
    dc = 0; dat = 0;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      if (k == 1) start1 = 1'b0;
      if (k == 3) begin a1 = 8'hAA; b1 = 8'h55; start1 = 1'b1; end
      if (k == 4) start1 = 1'b0;
      if (done1) begin dc++; dat = k; end
    end
    chk("t3_done_count", dc, 1);
    chk("t3_done_cycle", dat, 9);
    chk("t3_sum",  sum1, 8'h30);
    chk("t3_cout", cout1, 0);
    chk("t3_ovf",  ovf1, 0);

    // 0xC8 + 0x64 aborted by reset at t+4
    a1 = 8'hC8; b1 = 8'h64; cin1 = 1'b0; start1 = 1'b1;
    dc = 0;
    for (int k = 1; k <= 14; k++) begin
      @(negedge clk);
      if (k == 1) start1 = 1'b0;
      if (k == 4) rst = 1'b1;
      if (k == 5) begin
        rst = 1'b0;
        chk("t4_busy", busy1, 0);
        chk("t4_sum",  sum1, 0);
        chk("t4_cout", cout1, 0);
        chk("t4_ovf",  ovf1, 0);
      end
      if (done1) dc++;
    end
    chk("t4_no_done", dc, 0);

    // WIDTH=8, CHUNK=4: 0xFF + 0xFF + 1
    a2 = 8'hFF; b2 = 8'hFF; cin2 = 1'b1; start2 = 1'b1;
    bc = 0; dc = 0; dat = 0;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      if (k == 1) start2 = 1'b0;
      if (busy2) bc++;
      if (done2) begin dc++; dat = k; end
    end
    chk("t5_busy_cycles", bc, 2);
    chk("t5_done_count", dc, 1);
    chk("t5_done_cycle", dat, 3);
    chk("t5_sum",  sum2, 8'hFF);
    chk("t5_cout", cout2, 1);
    chk("t5_ovf",  ovf2, 0);

    // WIDTH=16, CHUNK=2: random back-to-back adds with start held high
    dn3 = 0;
    a3 = 16'($urandom); b3 = 16'($urandom); cin3 = 1'($urandom);
    start3 = 1'b1;
    acc3 = 1;
    for (int i = 0; i < 2000; i++) begin
      etot = 32'(a3) + 32'(b3) + 32'(cin3);
      ssum = int'($signed(a3)) + int'($signed(b3)) + int'(cin3);
      eovf = (ssum > 32767) || (ssum < -32768);
      w = 0;
      do begin
        @(negedge clk);
        w++;
      end while (!done3 && w < 12);
      chk("rnd_done", done3, 1);
      chk("rnd_sum", {cout3, sum3}, etot[16:0]);
      chk("rnd_ovf", ovf3, eovf);
      if (i < 1999) begin
        a3 = 16'($urandom); b3 = 16'($urandom); cin3 = 1'($urandom);
        acc3++;
      end else begin
        start3 = 1'b0;
      end
    end
    repeat (2) @(negedge clk);
    chk("rnd_done_count", dn3, acc3);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
